// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) reducer slice.
//   GF2M_M         default field degree (output width; the product is 2*M bits)
//   GF2M_POLY_LOW  default reduction polynomial with the x^M term dropped
//                  (x^224 + x^12 + x^7 + x^2 + 1)
//   gf2m_state_t   FSM state encoding shared by the top and the bench
package gf2m_pkg;

    localparam int GF2M_M = 224;

    localparam logic [GF2M_M-1:0] GF2M_POLY_LOW = 224'h1085;

    typedef logic [1:0] gf2m_state_t;

    localparam gf2m_state_t ST_IDLE   = 2'd0;
    localparam gf2m_state_t ST_REDUCE = 2'd1;
    localparam gf2m_state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/gf2m_reducer_if.sv
// Handshake bundle between the upstream multiplier, the reducer and the
// result consumer.
//   in_valid/in_ready/in_data    2M-bit carry-less product, valid/ready
//   out_valid/out_ready/out_data M-bit reduced result, valid/ready
//   busy                         reducer is stepping through a product
// Modports: slave = reducer side, master = producer/consumer side.
interface gf2m_reducer_if
    import gf2m_pkg::*;
#(
    parameter int M = GF2M_M
);
    logic           in_valid;
    logic           in_ready;
    logic [2*M-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [M-1:0]   out_data;
    logic           busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/gf2m_red_step.sv
// One long-division step of GF(2) polynomial reduction (pure combinational).
//   r       2M-bit working remainder
//   cnt     bit position being eliminated (M <= cnt <= 2M-1 when used)
//   r_next  r with bit cnt cancelled by x^cnt = x^(cnt-M) * POLY_LOW,
//           or r unchanged when bit cnt is already clear
module gf2m_red_step
    import gf2m_pkg::*;
#(
    parameter int             M        = GF2M_M,
    parameter logic [M-1:0]   POLY_LOW = M'(GF2M_POLY_LOW),
    parameter int             CNT_W    = $clog2(2*M)
) (
    input  logic [2*M-1:0]   r,
    input  logic [CNT_W-1:0] cnt,
    output logic [2*M-1:0]   r_next
);
    localparam logic [2*M-1:0] POLY_EXT = {{M{1'b0}}, POLY_LOW};
    localparam logic [2*M-1:0] ONE      = (2*M)'(1);

    logic [CNT_W-1:0] shamt;

    assign shamt = cnt - CNT_W'(M);

    // The shifted polynomial tops out at bit cnt-1, so bit cnt is cleared
    // separately by XORing in a single one at that position.
    always_comb begin
        r_next = r;
        if (r[cnt]) begin
            r_next = r ^ (POLY_EXT << shamt) ^ (ONE << cnt);
        end
    end
endmodule

// File: rtl/gf2m_reducer.sv
// GF(2^m) reducer: takes a 2M-bit carry-less product and returns
// product mod (x^M + POLY_LOW), one bit eliminated per clock.
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  gf2m_reducer_if.slave (in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, busy)
// Build option GF2M_REDUCER_EARLY_EXIT_EN: finish as soon as r[cnt:M] is
// all zero instead of always stepping M times (data-dependent latency).
module gf2m_reducer
    import gf2m_pkg::*;
#(
    parameter int           M        = GF2M_M,
    parameter logic [M-1:0] POLY_LOW = M'(GF2M_POLY_LOW)
) (
    input  logic           clk,
    input  logic           rst,
    gf2m_reducer_if.slave  bus
);
    localparam int               CNT_W   = $clog2(2*M);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(2*M-1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(M);

    gf2m_state_t      state;
    logic [2*M-1:0]   r;
    logic [2*M-1:0]   r_next;
    logic [CNT_W-1:0] cnt;
    logic [M-1:0]     out_data_q;
    logic             early_done;

    gf2m_red_step #(
        .M        (M),
        .POLY_LOW (POLY_LOW),
        .CNT_W    (CNT_W)
    ) u_step (
        .r      (r),
        .cnt    (cnt),
        .r_next (r_next)
    );

`ifdef GF2M_REDUCER_EARLY_EXIT_EN
    localparam logic [2*M-1:0] ONE   = (2*M)'(1);
    localparam logic [2*M-1:0] LOW_M = (ONE << M) - ONE;

    logic [CNT_W:0]   cnt_p1;
    logic [2*M-1:0]   upto_cnt;
    logic [2*M-1:0]   hi_mask;

    // hi_mask selects bits M..cnt; when those are all zero the remainder is
    // already fully reduced.
    assign cnt_p1     = {1'b0, cnt} + (CNT_W+1)'(1);
    assign upto_cnt   = (ONE << cnt_p1) - ONE;
    assign hi_mask    = upto_cnt & ~LOW_M;
    assign early_done = ((r & hi_mask) == '0);
`else
    assign early_done = 1'b0;
`endif

    // in_ready is qualified with rst so it stays low for the whole reset
    // pulse, including the cycle in which the state is still being cleared.
    assign bus.in_ready  = rst && (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state == ST_REDUCE);
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            r          <= '0;
            cnt        <= '0;
            out_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r     <= bus.in_data;
                        cnt   <= CNT_TOP;
                        state <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (early_done) begin
                        out_data_q <= r[M-1:0];
                        state      <= ST_DONE;
                    end else begin
                        r   <= r_next;
                        cnt <= cnt - CNT_W'(1);
                        // The edge that eliminates bit M is the last one;
                        // the result is captured from the stepped value.
                        if (cnt == CNT_END) begin
                            out_data_q <= r_next[M-1:0];
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf2m_reducer.sv
// Self-checking bench for gf2m_reducer: directed vectors, a reference
// polynomial-mod model built from a table of x^i mod p, stall, reset abort
// and back-to-back streaming.
module tb_gf2m_reducer;
    import gf2m_pkg::*;

    localparam int M = 224;
    localparam int W = 2*M;
    localparam logic [M-1:0] POLY = 224'h1085;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    gf2m_reducer_if #(.M(M)) bus ();

    gf2m_reducer #(.M(M), .POLY_LOW(POLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [M-1:0] pw [W];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [M-1:0] model(input logic [W-1:0] d);
        logic [M-1:0] acc;
        acc = '0;
        for (int i = 0; i < W; i++) begin
            if (d[i]) acc = acc ^ pw[i];
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] rand_prod();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W/32; i++) begin
            v = (v << 32) | W'($urandom);
        end
        return v;
    endfunction

    // Called at a negedge. Returns the result and the number of edges from
    // the accepting edge to the first cycle with out_valid (-1 on timeout).
    task automatic do_op(input logic [W-1:0] d, output logic [M-1:0] res, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 2000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.out_valid) lat = -1;
        res = bus.out_data;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    logic [M-1:0] res;
    int           lat;
    int           exp_lat_abcd;
    logic [W-1:0] one_w;
    logic [W-1:0] vec [3];
    logic [M-1:0] vexp [3];
    logic [M-1:0] held;
    logic [W-1:0] d2;

    initial begin
        pw[0] = M'(1);
        for (int i = 1; i < W; i++) begin
            pw[i] = (pw[i-1] << 1) ^ (pw[i-1][M-1] ? POLY : '0);
        end
`ifdef GF2M_REDUCER_EARLY_EXIT_EN
        exp_lat_abcd = 1;
`else
        exp_lat_abcd = M;
`endif
        one_w = W'(1);

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  W'(bus.in_ready),  W'(0));
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_busy",      W'(bus.busy),      W'(0));
        check("rst_out_data",  W'(bus.out_data),  W'(0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_in_ready", W'(bus.in_ready), W'(1));

        // x^224 -> POLY_LOW, fixed latency M (bit 224 stays set until the end)
        do_op(one_w << M, res, lat);
        check("x224_data", W'(res), W'(224'h1085));
        check("x224_lat",  W'(lat), W'(M));
        check("x224_ready_after", W'(bus.in_ready), W'(1));

        // Already reduced input passes through
        do_op(W'(448'hABCD), res, lat);
        check("abcd_data", W'(res), W'(224'hABCD));
        check("abcd_lat",  W'(lat), W'(exp_lat_abcd));

        // x^447 = x^223 * x^224 -> x^223*(x^12+x^7+x^2+1) mod p; checked against table
        do_op(one_w << (W-1), res, lat);
        check("x447_data", W'(res), W'(pw[W-1]));

        // x^225 -> x*POLY_LOW = 0x210A
        do_op(one_w << (M+1), res, lat);
        check("x225_data", W'(res), W'(224'h210A));

        // All ones
        do_op({W{1'b1}}, res, lat);
        check("ones_data", W'(res), W'(model({W{1'b1}})));

        // Random products
        for (int k = 0; k < 30; k++) begin
            d2 = rand_prod();
            do_op(d2, res, lat);
            check($sformatf("rand%0d", k), W'(res), W'(model(d2)));
        end

        // Stall: out_ready low for 10 cycles, a second product waiting
        d2 = rand_prod();
        bus.in_valid = 1'b1;
        bus.in_data  = W'(448'h1_2345_6789);
        @(posedge clk);
        @(negedge clk);
        bus.in_data = d2;
        begin
            int g;
            g = 0;
            while (!bus.out_valid && g < 2000) begin
                @(posedge clk);
                g++;
                @(negedge clk);
            end
        end
        check("stall_valid", W'(bus.out_valid), W'(1));
        held = bus.out_data;
        check("stall_first", W'(held), W'(model(W'(448'h1_2345_6789))));
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_hold",  W'(bus.out_data), W'(held));
            check("stall_nordy", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("stall_ready_back", W'(bus.in_ready), W'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("stall_second_busy", W'(bus.busy || bus.out_valid), W'(1));
        begin
            int g;
            g = 0;
            while (!bus.out_valid && g < 2000) begin
                @(posedge clk);
                g++;
                @(negedge clk);
            end
        end
        check("stall_second", W'(bus.out_data), W'(model(d2)));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset mid-REDUCE
        bus.in_valid = 1'b1;
        bus.in_data  = {W{1'b1}};
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (99) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_busy_before", W'(bus.busy), W'(1));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid",    W'(bus.out_valid), W'(0));
        check("abort_busy",     W'(bus.busy),      W'(0));
        check("abort_data",     W'(bus.out_data),  W'(0));
        check("abort_in_ready", W'(bus.in_ready),  W'(0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rel_ready", W'(bus.in_ready), W'(1));
        do_op(one_w << M, res, lat);
        check("abort_x224", W'(res), W'(224'h1085));

        // Back-to-back streaming
        vec[0] = one_w << M;
        vec[1] = W'(448'hABCD);
        vec[2] = rand_prod();
        for (int k = 0; k < 3; k++) vexp[k] = model(vec[k]);
        begin
            int idx, oidx, cyc;
            bit exp_rdy, took;
            idx = 0; oidx = 0; cyc = 0; exp_rdy = 0;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_data   = vec[0];
            while (oidx < 3 && cyc < 3000) begin
                if (exp_rdy) check("b2b_ready", W'(bus.in_ready), W'(1));
                exp_rdy = 0;
                if (bus.out_valid) begin
                    check($sformatf("b2b_out%0d", oidx), W'(bus.out_data), W'(vexp[oidx]));
                    oidx++;
                    exp_rdy = 1;
                end
                took = bus.in_ready && bus.in_valid;
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (took) begin
                    idx++;
                    if (idx < 3) bus.in_data = vec[idx];
                    else bus.in_valid = 1'b0;
                end
            end
            if (exp_rdy) check("b2b_ready_last", W'(bus.in_ready), W'(1));
            check("b2b_outputs", W'(oidx), W'(3));
            check("b2b_accepts", W'(idx),  W'(3));
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
            end
            check("b2b_no_dup", W'(bus.out_valid), W'(0));
            bus.out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
